dvp_capture_ctrl: RTL and testbench

Parametrised DVP camera capture controller, successor to the fixed 16-bit camera reader. It samples the sensor byte stream, assembles multi-byte pixels, and applies a crop window plus horizontal/vertical decimation. It emits pixels with a linear frame-buffer write address. It sits between the sensor pins and the frame-buffer write port, and adds single-shot/continuous frame modes, frame counting and line-error detection.

---
 rtl/dvp_capture_ctrl_if.sv | 13 +
 rtl/dvp_capture_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_dvp_capture_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_capture_ctrl_if.sv
// Pixel write bus from the capture controller to the frame-buffer write port.
interface dvp_capture_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int BPP    = 2,
  parameter int ADDR_W = 16
);
  logic [DATA_W*BPP-1:0] pix_data;
  logic                  pix_valid;
  logic [ADDR_W-1:0]     pix_addr;

  modport master (output pix_data, output pix_valid, output pix_addr);
  modport slave  (input  pix_data, input  pix_valid, input  pix_addr);
endinterface

// File: rtl/dvp_capture_ctrl.sv
// DVP camera capture controller: registers the sensor pins, assembles
// multi-byte pixels, applies a crop window with decimation and emits each
// accepted pixel with a linear frame-buffer write address.
module dvp_capture_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BPP       = 2,
  parameter int ADDR_W    = 16,
  parameter int X_START   = 0,
  parameter int Y_START   = 0,
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 240,
  parameter int DECIM     = 1,
  parameter bit VSYNC_POL = 1'b1,
  parameter bit BYTE_SWAP = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] csi_data,
  input  logic              csi_vsync,
  input  logic              csi_hsync,
  input  logic              cfg_continuous,
  input  logic              start,
  dvp_capture_ctrl_if.master pix_if,
  output logic              frame_start,
  output logic              frame_done,
  output logic              line_err,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int PIX_W = DATA_W * BPP;
  localparam int CNT_W = 16;
  localparam logic [1:0]       BYTE_LAST = 2'(BPP - 1);
  localparam logic [CNT_W-1:0] X_LO      = CNT_W'(X_START);
  localparam logic [CNT_W-1:0] Y_LO      = CNT_W'(Y_START);
  localparam logic [CNT_W-1:0] W_LIM     = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] H_LIM     = CNT_W'(HEIGHT);
  localparam logic [CNT_W-1:0] DEC_MASK  = CNT_W'(DECIM - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, SYNC, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q;
  logic               vs_q, hs_q, vs_prev_q, hs_prev_q;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PIX_W-1:0]   shift_q, shift_d;
  logic [PIX_W-1:0]   pix_data_q, pix_data_d;
  logic               pix_valid_q, pix_valid_d;
  logic [ADDR_W-1:0]  pix_addr_q, pix_addr_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_done_q, frame_done_d;
  logic               line_err_q, line_err_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;

  logic               vs_rise, vs_fall, hs_fall;
  logic [CNT_W-1:0]   col_rel, row_rel;
  logic               pix_ok;
  logic [PIX_W-1:0]   data_ext, shift_in;

  // Register the sensor pins once; vsync is normalised to active-high here.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      hs_prev_q <= 1'b0;
    end else begin
      data_q    <= csi_data;
      vs_q      <= (csi_vsync == VSYNC_POL);
      hs_q      <= csi_hsync;
      vs_prev_q <= vs_q;
      hs_prev_q <= hs_q;
    end
  end

  assign vs_rise = vs_q & ~vs_prev_q;
  assign vs_fall = ~vs_q & vs_prev_q;
  assign hs_fall = ~hs_q & hs_prev_q;

  // Offsets wrap to large values left of / above the window, so a single
  // unsigned compare covers both window edges.
  assign col_rel = col_q - X_LO;
  assign row_rel = row_q - Y_LO;
  assign pix_ok  = (col_rel < W_LIM) && (row_rel < H_LIM) &&
                   ((col_rel & DEC_MASK) == '0) && ((row_rel & DEC_MASK) == '0);

  // Shift register contents after taking the current byte; after BPP bytes
  // the first byte sits at the MSB end, or at the LSB end when swapped.
  assign data_ext = PIX_W'(data_q);
  assign shift_in = BYTE_SWAP ? ((shift_q >> DATA_W) | (data_ext << (PIX_W - DATA_W)))
                              : ((shift_q << DATA_W) | data_ext);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus counters, pixel assembly and output pulses.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    col_d         = col_q;
    row_d         = row_q;
    addr_d        = addr_q;
    shift_d       = shift_q;
    pix_data_d    = pix_data_q;
    pix_valid_d   = 1'b0;
    pix_addr_d    = pix_addr_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    line_err_d    = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        // Only a fresh vsync edge starts a frame, never a frame in progress.
        if (vs_rise) state_d = SYNC;
      end
      SYNC: begin
        if (vs_fall) begin
          state_d       = ACTIVE;
          byte_cnt_d    = '0;
          col_d         = '0;
          row_d         = '0;
          addr_d        = '0;
          frame_start_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          // Frame end wins over any byte or line end in the same cycle; a
          // partial pixel is simply dropped.
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          state_d      = cfg_continuous ? SYNC : IDLE;
        end else if (hs_q) begin
          shift_d = shift_in;
          if (byte_cnt_q == BYTE_LAST) begin
            byte_cnt_d = '0;
            col_d      = col_q + CNT_W'(1);
            if (pix_ok) begin
              pix_valid_d = 1'b1;
              pix_data_d  = shift_in;
              pix_addr_d  = addr_q;
              addr_d      = addr_q + ADDR_W'(1);
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (hs_fall) begin
          row_d      = row_q + CNT_W'(1);
          col_d      = '0;
          byte_cnt_d = '0;
          line_err_d = (byte_cnt_q != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_q    <= '0;
      col_q         <= '0;
      row_q         <= '0;
      addr_q        <= '0;
      shift_q       <= '0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_addr_q    <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      byte_cnt_q    <= byte_cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      addr_q        <= addr_d;
      shift_q       <= shift_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      pix_addr_q    <= pix_addr_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign pix_if.pix_data  = pix_data_q;
  assign pix_if.pix_valid = pix_valid_q;
  assign pix_if.pix_addr  = pix_addr_q;
  assign frame_start      = frame_start_q;
  assign frame_done       = frame_done_q;
  assign line_err         = line_err_q;
  assign frame_cnt        = frame_cnt_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Directed bench for dvp_capture_ctrl. Four instances share the sensor pins:
//   u0: 4x2 window, normal byte order
//   u1: crop X_START=2, Y_START=1, 3x2
//   u2: 8x4 window, DECIM=2
//   u3: 4x2 window, BYTE_SWAP=1, active-low vsync (fed the inverted pin)
module tb_dvp_capture_ctrl;
  localparam int N   = 4;
  localparam int CAP = 512;

  logic       clk = 1'b0;
  logic       reset, cfg_continuous, start, csi_vsync, csi_hsync;
  logic [7:0] csi_data;
  logic       csi_vsync_n;
  logic [N-1:0] fs, fd, le, bz, pv;
  logic [7:0]   fc [N];
  logic [15:0]  pd [N];
  logic [15:0]  pa [N];

  int n_chk  = 0;
  int n_fail = 0;
  int n_pix [N] = '{default: 0};
  int n_fs  [N] = '{default: 0};
  int n_fd  [N] = '{default: 0};
  int n_le  [N] = '{default: 0};
  logic [15:0] cap_d [N][CAP];
  logic [15:0] cap_a [N][CAP];
  logic [7:0]  seq;

  always #5 clk = ~clk;
  assign csi_vsync_n = ~csi_vsync;

  dvp_capture_ctrl_if #(.DATA_W(8), .BPP(2), .ADDR_W(16)) if0 ();
  dvp_capture_ctrl_if #(.DATA_W(8), .BPP(2), .ADDR_W(16)) if1 ();
  dvp_capture_ctrl_if #(.DATA_W(8), .BPP(2), .ADDR_W(16)) if2 ();
  dvp_capture_ctrl_if #(.DATA_W(8), .BPP(2), .ADDR_W(16)) if3 ();

  dvp_capture_ctrl #(.WIDTH(4), .HEIGHT(2)) u0 (
    .clk(clk), .reset(reset), .csi_data(csi_data), .csi_vsync(csi_vsync),
    .csi_hsync(csi_hsync), .cfg_continuous(cfg_continuous), .start(start),
    .pix_if(if0), .frame_start(fs[0]), .frame_done(fd[0]), .line_err(le[0]),
    .busy(bz[0]), .frame_cnt(fc[0]));

  dvp_capture_ctrl #(.X_START(2), .Y_START(1), .WIDTH(3), .HEIGHT(2)) u1 (
    .clk(clk), .reset(reset), .csi_data(csi_data), .csi_vsync(csi_vsync),
    .csi_hsync(csi_hsync), .cfg_continuous(cfg_continuous), .start(start),
    .pix_if(if1), .frame_start(fs[1]), .frame_done(fd[1]), .line_err(le[1]),
    .busy(bz[1]), .frame_cnt(fc[1]));

  dvp_capture_ctrl #(.WIDTH(8), .HEIGHT(4), .DECIM(2)) u2 (
    .clk(clk), .reset(reset), .csi_data(csi_data), .csi_vsync(csi_vsync),
    .csi_hsync(csi_hsync), .cfg_continuous(cfg_continuous), .start(start),
    .pix_if(if2), .frame_start(fs[2]), .frame_done(fd[2]), .line_err(le[2]),
    .busy(bz[2]), .frame_cnt(fc[2]));

  dvp_capture_ctrl #(.WIDTH(4), .HEIGHT(2), .BYTE_SWAP(1'b1), .VSYNC_POL(1'b0)) u3 (
    .clk(clk), .reset(reset), .csi_data(csi_data), .csi_vsync(csi_vsync_n),
    .csi_hsync(csi_hsync), .cfg_continuous(cfg_continuous), .start(start),
    .pix_if(if3), .frame_start(fs[3]), .frame_done(fd[3]), .line_err(le[3]),
    .busy(bz[3]), .frame_cnt(fc[3]));

  assign pv[0] = if0.pix_valid;  assign pd[0] = if0.pix_data;  assign pa[0] = if0.pix_addr;
  assign pv[1] = if1.pix_valid;  assign pd[1] = if1.pix_data;  assign pa[1] = if1.pix_addr;
  assign pv[2] = if2.pix_valid;  assign pd[2] = if2.pix_data;  assign pa[2] = if2.pix_addr;
  assign pv[3] = if3.pix_valid;  assign pd[3] = if3.pix_data;  assign pa[3] = if3.pix_addr;

  // Record every strobe and pulse on the falling edge, away from the DUT edge.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (pv[k] === 1'b1) begin
        if (n_pix[k] < CAP) begin
          cap_d[k][n_pix[k]] <= pd[k];
          cap_a[k][n_pix[k]] <= pa[k];
        end
        n_pix[k] <= n_pix[k] + 1;
      end
      if (fs[k] === 1'b1) n_fs[k] <= n_fs[k] + 1;
      if (fd[k] === 1'b1) n_fd[k] <= n_fd[k] + 1;
      if (le[k] === 1'b1) n_le[k] <= n_le[k] + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic [7:0] d, input logic vs, input logic hs);
    @(posedge clk); #2;
    csi_data  = d;
    csi_vsync = vs;
    csi_hsync = hs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0);
  endtask

  task automatic vs_pulse();
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b1, 1'b0);
    idle(3);
  endtask

  task automatic send_lines(input int cols, input int rows);
    for (int r = 0; r < rows; r++) begin
      for (int b = 0; b < cols * 2; b++) begin
        cyc(seq, 1'b0, 1'b1);
        seq = seq + 8'd1;
      end
      idle(2);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1; start = 1'b0;
    csi_data = 8'h00; csi_vsync = 1'b0; csi_hsync = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  function automatic logic [15:0] pix_at(input int r, input int c, input int cols);
    int p;
    p = r * cols + c;
    return {8'(2 * p + 1), 8'(2 * p + 2)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk); #2;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if ({pv[k], fs[k], fd[k], le[k], bz[k]} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_pulses u%0d: got %b expected 00000", k, {pv[k], fs[k], fd[k], le[k], bz[k]});
      end
      n_chk++;
      if ({fc[k], pd[k], pa[k]} !== 40'h0) begin
        n_fail++;
        $display("FAIL reset_values u%0d: got cnt=%h data=%h addr=%h expected 0", k, fc[k], pd[k], pa[k]);
      end
    end
    start = 1'b0; reset = 1'b0;
    idle(3);
    n_chk++;
    if (bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL start_with_reset busy: got %b expected 0", bz[0]);
    end
  endtask

  task automatic test_single_frame();
    int b0, b3, bf, bs;
    do_reset(); cfg_continuous = 1'b0;
    b0 = n_pix[0]; b3 = n_pix[3]; bf = n_fd[0]; bs = n_fs[0];
    pulse_start(); vs_pulse();
    seq = 8'h01; send_lines(4, 2);
    vs_pulse(); idle(4);
    n_chk++;
    if (n_pix[0] - b0 != 8) begin
      n_fail++; $display("FAIL frame_strobes: got %0d expected 8", n_pix[0] - b0);
    end
    n_chk++;
    if (cap_d[0][b0] !== 16'h0102) begin
      n_fail++; $display("FAIL frame_first_data: got %h expected 0102", cap_d[0][b0]);
    end
    n_chk++;
    if (cap_d[0][b0+7] !== 16'h0F10) begin
      n_fail++; $display("FAIL frame_last_data: got %h expected 0f10", cap_d[0][b0+7]);
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (cap_a[0][b0+i] !== 16'(i)) begin
        n_fail++; $display("FAIL frame_addr[%0d]: got %0d expected %0d", i, cap_a[0][b0+i], i);
      end
    end
    n_chk++;
    if (n_fd[0] - bf != 1 || n_fs[0] - bs != 1) begin
      n_fail++; $display("FAIL frame_pulses: got done=%0d start=%0d expected 1 1", n_fd[0] - bf, n_fs[0] - bs);
    end
    n_chk++;
    if (fc[0] !== 8'd1) begin
      n_fail++; $display("FAIL frame_cnt: got %0d expected 1", fc[0]);
    end
    n_chk++;
    if (n_pix[3] - b3 != 8 || cap_d[3][b3] !== 16'h0201) begin
      n_fail++; $display("FAIL swap_lowvs_frame: got n=%0d first=%h expected 8 0201", n_pix[3] - b3, cap_d[3][b3]);
    end
  endtask

  task automatic test_crop();
    int b, i;
    do_reset(); cfg_continuous = 1'b0;
    b = n_pix[1];
    pulse_start(); vs_pulse();
    seq = 8'h01; send_lines(8, 4);
    vs_pulse(); idle(4);
    n_chk++;
    if (n_pix[1] - b != 6) begin
      n_fail++; $display("FAIL crop_strobes: got %0d expected 6", n_pix[1] - b);
    end
    i = 0;
    for (int r = 1; r <= 2; r++) begin
      for (int c = 2; c <= 4; c++) begin
        n_chk++;
        if (cap_d[1][b+i] !== pix_at(r, c, 8) || cap_a[1][b+i] !== 16'(i)) begin
          n_fail++;
          $display("FAIL crop_pix[%0d]: got %h@%0d expected %h@%0d", i, cap_d[1][b+i], cap_a[1][b+i], pix_at(r, c, 8), i);
        end
        i++;
      end
    end
  endtask

  task automatic test_decim();
    int b, i;
    do_reset(); cfg_continuous = 1'b0;
    b = n_pix[2];
    pulse_start(); vs_pulse();
    seq = 8'h01; send_lines(8, 4);
    vs_pulse(); idle(4);
    n_chk++;
    if (n_pix[2] - b != 8) begin
      n_fail++; $display("FAIL decim_strobes: got %0d expected 8", n_pix[2] - b);
    end
    i = 0;
    for (int r = 0; r < 4; r += 2) begin
      for (int c = 0; c < 8; c += 2) begin
        n_chk++;
        if (cap_d[2][b+i] !== pix_at(r, c, 8) || cap_a[2][b+i] !== 16'(i)) begin
          n_fail++;
          $display("FAIL decim_pix[%0d]: got %h@%0d expected %h@%0d", i, cap_d[2][b+i], cap_a[2][b+i], pix_at(r, c, 8), i);
        end
        i++;
      end
    end
  endtask

  task automatic test_frame_modes(input logic cont);
    int b, bf, nf;
    nf = cont ? 3 : 1;
    do_reset(); cfg_continuous = cont;
    b = n_pix[0]; bf = n_fd[0];
    pulse_start(); vs_pulse();
    seq = 8'h01; send_lines(4, 2);
    n_chk++;
    if (bz[0] !== 1'b1) begin
      n_fail++; $display("FAIL mode%0d_busy_capturing: got %b expected 1", cont, bz[0]);
    end
    vs_pulse(); send_lines(4, 2);
    vs_pulse(); send_lines(4, 2);
    vs_pulse(); idle(4);
    n_chk++;
    if (n_pix[0] - b != 8 * nf || n_fd[0] - bf != nf) begin
      n_fail++; $display("FAIL mode%0d_counts: got pix=%0d done=%0d expected %0d %0d", cont, n_pix[0] - b, n_fd[0] - bf, 8 * nf, nf);
    end
    n_chk++;
    if (fc[0] !== 8'(nf)) begin
      n_fail++; $display("FAIL mode%0d_frame_cnt: got %0d expected %0d", cont, fc[0], nf);
    end
    n_chk++;
    if (bz[0] !== cont) begin
      n_fail++; $display("FAIL mode%0d_busy_end: got %b expected %b", cont, bz[0], cont);
    end
    if (cont) begin
      n_chk++;
      if (cap_a[0][b+8] !== 16'd0 || cap_d[0][b+8] !== 16'h1112 || cap_a[0][b+23] !== 16'd7) begin
        n_fail++;
        $display("FAIL cont_second_frame: got %h@%0d last@%0d expected 1112@0 last@7", cap_d[0][b+8], cap_a[0][b+8], cap_a[0][b+23]);
      end
    end
  endtask

  task automatic test_line_err();
    int b0, b3, l0, l3;
    do_reset(); cfg_continuous = 1'b0;
    b0 = n_pix[0]; b3 = n_pix[3]; l0 = n_le[0]; l3 = n_le[3];
    pulse_start(); vs_pulse();
    cyc(8'h11, 1'b0, 1'b1); cyc(8'h22, 1'b0, 1'b1); cyc(8'h33, 1'b0, 1'b1);
    idle(2);
    cyc(8'hAA, 1'b0, 1'b1); cyc(8'h55, 1'b0, 1'b1);
    idle(2);
    vs_pulse(); idle(3);
    n_chk++;
    if (n_le[0] - l0 != 1 || n_le[3] - l3 != 1) begin
      n_fail++; $display("FAIL line_err_pulses: got %0d %0d expected 1 1", n_le[0] - l0, n_le[3] - l3);
    end
    n_chk++;
    if (n_pix[0] - b0 != 2 || cap_d[0][b0] !== 16'h1122) begin
      n_fail++; $display("FAIL line_err_partial: got n=%0d first=%h expected 2 1122", n_pix[0] - b0, cap_d[0][b0]);
    end
    n_chk++;
    if (cap_d[0][b0+1] !== 16'hAA55 || cap_a[0][b0+1] !== 16'd1) begin
      n_fail++; $display("FAIL line_err_clean_next: got %h@%0d expected aa55@1", cap_d[0][b0+1], cap_a[0][b0+1]);
    end
    n_chk++;
    if (n_pix[3] - b3 != 2 || cap_d[3][b3+1] !== 16'h55AA) begin
      n_fail++; $display("FAIL byte_swap: got n=%0d data=%h expected 2 55aa", n_pix[3] - b3, cap_d[3][b3+1]);
    end
  endtask

  task automatic test_vs_during_hs();
    int b, l, f;
    do_reset(); cfg_continuous = 1'b0;
    b = n_pix[0]; l = n_le[0]; f = n_fd[0];
    pulse_start(); vs_pulse();
    cyc(8'h01, 1'b0, 1'b1); cyc(8'h02, 1'b0, 1'b1); cyc(8'h03, 1'b0, 1'b1);
    cyc(8'h04, 1'b1, 1'b1);
    cyc(8'h00, 1'b1, 1'b0); cyc(8'h00, 1'b1, 1'b0);
    idle(4);
    n_chk++;
    if (n_le[0] - l != 0 || n_fd[0] - f != 1) begin
      n_fail++; $display("FAIL vs_in_hs_pulses: got err=%0d done=%0d expected 0 1", n_le[0] - l, n_fd[0] - f);
    end
    n_chk++;
    if (n_pix[0] - b != 1 || cap_d[0][b] !== 16'h0102) begin
      n_fail++; $display("FAIL vs_in_hs_pixels: got n=%0d first=%h expected 1 0102", n_pix[0] - b, cap_d[0][b]);
    end
  endtask

  task automatic test_start_mid_frame();
    int b, s, f;
    do_reset(); cfg_continuous = 1'b0;
    b = n_pix[0]; s = n_fs[0]; f = n_fd[0];
    seq = 8'h01; send_lines(4, 1);
    pulse_start();
    send_lines(4, 1); idle(2);
    n_chk++;
    if (n_pix[0] - b != 0 || n_fs[0] - s != 0 || bz[0] !== 1'b1) begin
      n_fail++; $display("FAIL mid_start_wait: got pix=%0d fs=%0d busy=%b expected 0 0 1", n_pix[0] - b, n_fs[0] - s, bz[0]);
    end
    vs_pulse();
    seq = 8'h01; send_lines(4, 1);
    vs_pulse(); idle(3);
    n_chk++;
    if (n_pix[0] - b != 4 || cap_a[0][b] !== 16'd0 || cap_d[0][b] !== 16'h0102 || n_fd[0] - f != 1) begin
      n_fail++;
      $display("FAIL mid_start_capture: got pix=%0d first=%h@%0d done=%0d expected 4 0102@0 1", n_pix[0] - b, cap_d[0][b], cap_a[0][b], n_fd[0] - f);
    end
  endtask

  task automatic test_reset_mid_frame();
    int b;
    do_reset(); cfg_continuous = 1'b1;
    pulse_start(); vs_pulse();
    seq = 8'h01; send_lines(4, 2);
    vs_pulse();
    cyc(8'hA1, 1'b0, 1'b1); cyc(8'hA2, 1'b0, 1'b1);
    cyc(8'hA3, 1'b0, 1'b1); cyc(8'hA4, 1'b0, 1'b1);
    n_chk++;
    if (pv[0] !== 1'b1 || pd[0] !== 16'hA1A2 || pa[0] !== 16'd0 || fc[0] !== 8'd1 || bz[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: got v=%b d=%h a=%0d cnt=%0d busy=%b expected 1 a1a2 0 1 1", pv[0], pd[0], pa[0], fc[0], bz[0]);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if ({pv[0], fs[0], fd[0], le[0], bz[0]} !== 5'b0 || {fc[0], pd[0], pa[0]} !== 40'h0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b d=%h a=%h cnt=%0d busy=%b expected all 0", pv[0], pd[0], pa[0], fc[0], bz[0]);
    end
    @(posedge clk); #2; reset = 1'b0;
    csi_hsync = 1'b0;
    b = n_pix[0];
    vs_pulse(); send_lines(4, 2); vs_pulse(); idle(3);
    n_chk++;
    if (n_pix[0] - b != 0 || bz[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_to_idle: got pix=%0d busy=%b expected 0 0", n_pix[0] - b, bz[0]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_continuous = 1'b0;
    csi_data = 8'h00; csi_vsync = 1'b0; csi_hsync = 1'b0;
    seq = 8'h00;
    test_reset();
    test_single_frame();
    test_crop();
    test_decim();
    test_frame_modes(1'b0);
    test_frame_modes(1'b1);
    test_line_err();
    test_vs_during_hs();
    test_start_mid_frame();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
